vjtag_dr_engine: RTL and testbench

Parametrised Data-Register engine for the Virtual JTAG hub instance. Runs in the TCK domain and decodes the IR into BYPASS / ADDR / WRITE / READ. Implements LSB-first DR shifting with capture and update. Drives a single-port memory-side bus with address auto-increment, which lets the host stream bursts of image pixels in or out of the DSA without re-sending addresses.

---
 rtl/vjtag_dr_engine.sv | 166 ++++++++++++++++
 tb/tb_vjtag_dr_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vjtag_dr_engine.sv
// Virtual JTAG data-register engine.
// Decodes the virtual IR into BYPASS / ADDR / WRITE / READ, shifts DRs
// LSB-first in the TCK domain and drives a single-port memory bus whose
// address auto-increments so a host can burst words without re-addressing.
//
// Memory bus strobe semantics: mem_we and mem_re are single-cycle strobes
// and are never high together. mem_we qualifies mem_addr/mem_wdata in the
// cycle it is high. mem_re qualifies mem_addr in the cycle it is high, and
// the memory returns mem_rdata in the following cycle. There is no
// back-pressure: the memory must accept every strobe.
module vjtag_dr_engine #(
  parameter int IR_WIDTH   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  tck,
  input  logic                  rst,
  input  logic                  tdi,
  output logic                  tdo,
  input  logic [IR_WIDTH-1:0]   ir_in,
  output logic [IR_WIDTH-1:0]   ir_out,
  input  logic                  virtual_state_cdr,
  input  logic                  virtual_state_sdr,
  input  logic                  virtual_state_udr,
  input  logic                  virtual_state_uir,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wrap_err
);

  localparam int SR_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

  typedef enum logic [1:0] {
    OP_BYPASS = 2'd0,
    OP_ADDR   = 2'd1,
    OP_WRITE  = 2'd2,
    OP_READ   = 2'd3
  } op_e;

  op_e op;

  logic [SR_W-1:0]       sr_q, sr_d;
  logic                  byp_q, byp_d;
  logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic                  wrap_err_q, wrap_err_d;
  logic [IR_WIDTH-1:0]   ir_out_q, ir_out_d;
  logic                  inc_pend_q, inc_pend_d;  // post-write address bump
  logic                  rd_pend_q, rd_pend_d;    // read data arrives this cycle

  // Instruction decode; any set bit above [1:0] falls back to BYPASS.
  always_comb begin
    op = OP_BYPASS;
    if ((ir_in >> 2) == '0) op = op_e'(ir_in[1:0]);
  end

  // Next-state logic: background address/readback work, then TAP strobes
  // with priority UIR > UDR > CDR > SDR.
  always_comb begin
    sr_d        = sr_q;
    byp_d       = byp_q;
    rd_hold_d   = rd_hold_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    wrap_err_d  = wrap_err_q;
    inc_pend_d  = 1'b0;
    rd_pend_d   = mem_re_q;

    if (rd_pend_q) rd_hold_d = mem_rdata;

    if (inc_pend_q) begin
      if (&mem_addr_q) wrap_err_d = 1'b1;
      mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
    end

    if (virtual_state_uir) begin
      // Entering READ primes rd_hold with the word at the current address.
      if (op == OP_READ) mem_re_d = 1'b1;
    end else if (virtual_state_udr) begin
      case (op)
        OP_ADDR: begin
          mem_addr_d = sr_q[ADDR_WIDTH-1:0];
          wrap_err_d = 1'b0;
        end
        OP_WRITE: begin
          mem_wdata_d = sr_q[DATA_WIDTH-1:0];
          mem_we_d    = 1'b1;
          inc_pend_d  = 1'b1;
        end
        default: ;
      endcase
    end else if (virtual_state_cdr) begin
      case (op)
        OP_BYPASS: byp_d = 1'b0;
        OP_ADDR: begin
          sr_d                 = '0;
          sr_d[ADDR_WIDTH-1:0] = mem_addr_q;
        end
        OP_WRITE: sr_d = '0;
        OP_READ: begin
          // Hand out the prefetched word and fetch the next one.
          sr_d                 = '0;
          sr_d[DATA_WIDTH-1:0] = rd_hold_q;
          if (&mem_addr_q) wrap_err_d = 1'b1;
          mem_addr_d           = mem_addr_q + ADDR_WIDTH'(1);
          mem_re_d             = 1'b1;
        end
        default: ;
      endcase
    end else if (virtual_state_sdr) begin
      case (op)
        OP_BYPASS: byp_d = tdi;
        OP_ADDR:   sr_d[ADDR_WIDTH-1:0] = {tdi, sr_q[ADDR_WIDTH-1:1]};
        default:   sr_d[DATA_WIDTH-1:0] = {tdi, sr_q[DATA_WIDTH-1:1]};
      endcase
    end

    ir_out_d = {{(IR_WIDTH-1){1'b0}}, wrap_err_d};
  end

  // State registers with synchronous reset.
  always_ff @(posedge tck) begin
    if (rst) begin
      sr_q        <= '0;
      byp_q       <= 1'b0;
      rd_hold_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      wrap_err_q  <= 1'b0;
      ir_out_q    <= '0;
      inc_pend_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      byp_q       <= byp_d;
      rd_hold_q   <= rd_hold_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      wrap_err_q  <= wrap_err_d;
      ir_out_q    <= ir_out_d;
      inc_pend_q  <= inc_pend_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  assign tdo       = (op == OP_BYPASS) ? byp_q : sr_q[0];
  assign ir_out    = ir_out_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign wrap_err  = wrap_err_q;

endmodule

// File: tb/tb_vjtag_dr_engine.sv
// Bench for vjtag_dr_engine: directed scenarios followed by random
// operations, with memory strobes checked through an expected queue.
module tb_vjtag_dr_engine;

  localparam int IRW = 3;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int EW  = 2 + AW + DW;

  localparam logic [IRW-1:0] IR_BYP  = 3'd0;
  localparam logic [IRW-1:0] IR_ADDR = 3'd1;
  localparam logic [IRW-1:0] IR_WR   = 3'd2;
  localparam logic [IRW-1:0] IR_RD   = 3'd3;
  localparam logic [IRW-1:0] IR_HI   = 3'b100;

  // ---------------- clock / reset / DUT ----------------
  logic          tck = 1'b0;
  logic          rst = 1'b1;
  logic          tdi = 1'b0;
  logic          tdo;
  logic [IRW-1:0] ir_in = '0;
  logic [IRW-1:0] ir_out;
  logic          cdr = 1'b0, sdr = 1'b0, udr = 1'b0, uir = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata = '0;
  logic          wrap_err;

  always #5 tck = ~tck;

  vjtag_dr_engine #(.IR_WIDTH(IRW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .tck(tck), .rst(rst), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .virtual_state_cdr(cdr), .virtual_state_sdr(sdr),
    .virtual_state_udr(udr), .virtual_state_uir(uir),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .wrap_err(wrap_err)
  );

  // Environment memory: write on mem_we, read data one cycle after mem_re,
  // garbage on the bus otherwise.
  logic [DW-1:0] env_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge tck) begin
    if (mem_we) env_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= env_mem[mem_addr];
    else        mem_rdata <= DW'($urandom);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_act, mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe seen on the bus must match the next expected one.
  always @(negedge tck) begin
    if (mem_we && mem_re) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_excl: mem_we and mem_re both high at %0t", $time);
    end else if (mem_we || mem_re) begin
      mon_act = {mem_we, mem_re, mem_addr, mem_we ? mem_wdata : {DW{1'b0}}};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got 0x%0h expected none at %0t", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL strobe: got 0x%0h expected 0x%0h at %0t", mon_act, mon_exp, $time);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [AW-1:0] m_addr = '0;
  logic          m_wrap = 1'b0;
  logic [DW-1:0] m_rd   = '0;

  task automatic m_inc();
    if (m_addr == {AW{1'b1}}) m_wrap = 1'b1;
    m_addr = m_addr + AW'(1);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(m_addr));
    check({tag, "_wrap_err"}, 32'(wrap_err), 32'(m_wrap));
    check({tag, "_ir_out"},   32'(ir_out),   32'({{(IRW-1){1'b0}}, m_wrap}));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge tck);
  endtask

  task automatic set_ir(input logic [IRW-1:0] v);
    ir_in = v;
    uir = 1'b1;
    tick();
    uir = 1'b0;
  endtask

  task automatic scan(input int len, input logic [AW-1:0] din, output logic [AW-1:0] dout);
    dout = '0;
    cdr = 1'b1;
    tick();
    cdr = 1'b0;
    for (int i = 0; i < len; i++) begin
      sdr = 1'b1;
      tdi = din[i];
      dout[i] = tdo;
      tick();
    end
    sdr = 1'b0;
    tdi = 1'b0;
    udr = 1'b1;
    tick();
    udr = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_set_addr(input logic [AW-1:0] a);
    logic [AW-1:0] d;
    set_ir(IR_ADDR);
    scan(AW, a, d);
    check("addr_capture", 32'(d), 32'(m_addr));
    m_addr = a;
    m_wrap = 1'b0;
    check_state("set_addr");
  endtask

  task automatic do_write(input logic [DW-1:0] w);
    logic [AW-1:0] d;
    set_ir(IR_WR);
    exp_q.push_back({2'b10, m_addr, w});
    scan(DW, AW'(w), d);
    check("write_capture", 32'(d), 32'h0);
    ref_mem[m_addr] = w;
    m_inc();
    check_state("write");
  endtask

  task automatic do_read_start();
    exp_q.push_back({2'b01, m_addr, {DW{1'b0}}});
    m_rd = ref_mem[m_addr];
    set_ir(IR_RD);
    tick();
    tick();
    tick();
    check_state("read_start");
  endtask

  task automatic do_read_scan();
    logic [AW-1:0] d;
    m_inc();
    exp_q.push_back({2'b01, m_addr, {DW{1'b0}}});
    scan(DW, AW'($urandom), d);
    check("read_data", 32'(d), 32'(m_rd));
    m_rd = ref_mem[m_addr];
    check_state("read_scan");
  endtask

  task automatic do_bypass(input logic [IRW-1:0] code, input logic [3:0] pat);
    logic [AW-1:0] d;
    logic [3:0]    e;
    set_ir(code);
    scan(4, AW'(pat), d);
    e = pat << 1;
    check("bypass_echo", 32'(d), 32'(e));
    check_state("bypass");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      env_mem[i] = DW'($urandom);
      ref_mem[i] = env_mem[i];
    end
    env_mem[16'h20] = 8'hA0; ref_mem[16'h20] = 8'hA0;
    env_mem[16'h21] = 8'hA1; ref_mem[16'h21] = 8'hA1;
    env_mem[16'h22] = 8'hA2; ref_mem[16'h22] = 8'hA2;

    // Power-on reset.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_state("reset");
    check("reset_tdo", 32'(tdo), 32'h0);
    check("reset_wdata", 32'(mem_wdata), 32'h0);

    // Address load and readback.
    do_set_addr(16'h1234);
    do_set_addr(16'h0010);
    check("addr_readback_seen", 32'(m_addr), 32'h0010);

    // Three-word write burst.
    do_write(8'h11);
    do_write(8'h22);
    do_write(8'h33);
    check("write_burst_end", 32'(mem_addr), 32'h0013);

    // Address wrap sets the sticky flag; ADDR update clears it.
    do_set_addr(16'hFFFF);
    do_write(8'h5C);
    check("wrap_ir_out", 32'(ir_out), 32'h1);
    do_set_addr(16'h0100);

    // Reset in the middle of a WRITE shift of 0xA5.
    set_ir(IR_WR);
    cdr = 1'b1;
    tick();
    cdr = 1'b0;
    for (int i = 0; i < DW; i++) begin
      sdr = 1'b1;
      tdi = (8'hA5 >> i) & 8'h1;
      tick();
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sdr = 1'b0;
    tdi = 1'b0;
    tick();
    tick();
    m_addr = '0;
    m_wrap = 1'b0;
    m_rd   = '0;
    check_state("mid_reset");
    check("mid_reset_tdo", 32'(tdo), 32'h0);
    check("mid_reset_wdata", 32'(mem_wdata), 32'h0);
    check("mid_reset_we", 32'(mem_we), 32'h0);

    // Read burst from 0x20.
    do_set_addr(16'h0020);
    do_read_start();
    do_read_scan();
    do_read_scan();
    do_read_scan();
    check("read_burst_end", 32'(mem_addr), 32'h0023);

    // Bypass, including codes with upper IR bits set.
    do_bypass(IR_BYP, 4'b1101);
    do_bypass(IR_HI, 4'b1101);
    do_bypass(3'b111, 4'b0110);

    // Random operations.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          if ($urandom_range(0, 2) == 0) do_set_addr(AW'(16'hFFFE + $urandom_range(0, 1)));
          else                           do_set_addr(AW'($urandom));
        end
        1: begin
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) do_write(DW'($urandom));
        end
        2: begin
          do_read_start();
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) do_read_scan();
        end
        default: begin
          do_bypass(($urandom_range(0, 1) == 0) ? IR_BYP : IRW'($urandom_range(4, 7)),
                    4'($urandom));
        end
      endcase
    end

    repeat (4) tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
